sec_ded_enc_stream: RTL and testbench

SEC_DED_ENC_STREAM -- requirements
Module: sec_ded_enc_stream

---
 rtl/sec_ded_enc_stream.sv | 101 ++++++++++
 tb/tb_sec_ded_enc_stream.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_ded_enc_stream.sv
// SEC-DED (39,32) encoder, two-stage valid/ready pipeline.
// Ports: clk, rst_n, in_valid/in_ready/in_data/inj_mask (upstream),
//        out_valid/out_ready/out (downstream), word_cnt (delivered count).
module sec_ded_enc_stream #(
    parameter bit INJ_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [38:0] inj_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [38:0] out,
    output logic [15:0] word_cnt
);

    logic        s1v_q, s1v_d;
    logic        s2v_q, s2v_d;
    logic [31:0] s1_data_q, s1_data_d;
    logic [38:0] s1_mask_q, s1_mask_d;
    logic [38:0] s2_cw_q, s2_cw_d;
    logic [15:0] cnt_q, cnt_d;

    logic        s2ld;
    logic        s1ld;
    logic        in_xfer;
    logic        out_xfer;
    logic [6:0]  c;
    logic [31:0] d;
    logic [38:0] cw;

    always_comb begin
        s2ld     = s1v_q & (~s2v_q | out_ready);
        s1ld     = ~s1v_q | s2ld;
        in_xfer  = in_valid & s1ld;
        out_xfer = s2v_q & out_ready;

        // S1 empties when it advances and nothing replaces it
        s1v_d = s1ld ? in_valid : s1v_q;

        if (s2ld)
            s2v_d = 1'b1;
        else if (out_xfer)
            s2v_d = 1'b0;
        else
            s2v_d = s2v_q;

        s1_data_d = in_xfer ? in_data : s1_data_q;
        // mask is only kept when injection is built in
        s1_mask_d = in_xfer ? (INJ_EN ? inj_mask : '0) : s1_mask_q;

        cnt_d = cnt_q + {15'd0, out_xfer};
    end

    // check bits from S1 contents only
    always_comb begin
        d = s1_data_q;
        c[0] = (^d[8:0]) ^ d[13] ^ d[17] ^ d[26] ^ d[27] ^ d[29];
        c[1] = (^d[4:0]) ^ d[12] ^ d[16] ^ d[18] ^ (^d[25:21])
             ^ d[28];
        c[2] = d[0] ^ (^d[8:5]) ^ d[11] ^ d[15] ^ d[18] ^ d[19]
             ^ d[21] ^ d[22] ^ d[30] ^ d[31];
        c[3] = d[1] ^ d[5] ^ d[10] ^ d[14] ^ (^d[20:18]) ^ d[23]
             ^ d[24] ^ (^d[30:26]);
        c[4] = d[2] ^ d[6] ^ d[9] ^ (^d[17:14]) ^ (^d[21:19])
             ^ d[23] ^ d[25] ^ d[29] ^ d[31];
        c[5] = d[3] ^ d[7] ^ (^d[13:9]) ^ d[20] ^ d[22] ^ d[24]
             ^ d[25] ^ d[27] ^ d[31];
        c[6] = d[4] ^ (^d[17:8]) ^ d[26] ^ d[28] ^ d[30];
        cw = {c, d} ^ s1_mask_q;
        s2_cw_d = s2ld ? cw : s2_cw_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1v_q   <= 1'b0;
            s2v_q   <= 1'b0;
            s2_cw_q <= '0;
            cnt_q   <= '0;
        end else begin
            s1v_q   <= s1v_d;
            s2v_q   <= s2v_d;
            s2_cw_q <= s2_cw_d;
            cnt_q   <= cnt_d;
        end
    end

    // payload register, no reset needed
    always_ff @(posedge clk) begin
        s1_data_q <= s1_data_d;
        s1_mask_q <= s1_mask_d;
    end

    assign in_ready  = s1ld;
    assign out_valid = s2v_q;
    assign out       = s2_cw_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_sec_ded_enc_stream.sv
// Scoreboard bench for sec_ded_enc_stream.
// Two instances: injection disabled (main) and enabled (inj).
module tb_sec_ded_enc_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data;
    logic [38:0] inj_mask, out;
    logic [15:0] word_cnt;

    logic        i_valid, i_ready, i_ovalid, i_oready;
    logic [31:0] i_data;
    logic [38:0] i_mask, i_out;
    logic [15:0] i_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt = 0;
    logic [38:0] exp_q[$];
    logic [38:0] iexp_q[$];
    bit rnd = 0;

    always #5 clk = ~clk;

    sec_ded_enc_stream #(.INJ_EN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .inj_mask(inj_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .word_cnt(word_cnt)
    );

    sec_ded_enc_stream #(.INJ_EN(1'b1)) dut_inj (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i_valid), .in_ready(i_ready),
        .in_data(i_data), .inj_mask(i_mask),
        .out_valid(i_ovalid), .out_ready(i_oready),
        .out(i_out), .word_cnt(i_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // reference encoder written from the check-bit membership lists
    function automatic logic [38:0] enc(input logic [31:0] dd);
        logic [6:0] cc;
        cc = '0;
        for (int b = 0; b < 32; b++) begin
            if (dd[b]) begin
                if (b inside {[0:8], 13, 17, 26, 27, 29}) cc[0] = ~cc[0];
                if (b inside {[0:4], 12, 16, 18, [21:25], 28}) cc[1] = ~cc[1];
                if (b inside {0, [5:8], 11, 15, 18, 19, 21, 22, 30, 31})
                    cc[2] = ~cc[2];
                if (b inside {1, 5, 10, 14, [18:20], 23, 24, [26:30]})
                    cc[3] = ~cc[3];
                if (b inside {2, 6, 9, [14:17], [19:21], 23, 25, 29, 31})
                    cc[4] = ~cc[4];
                if (b inside {3, 7, [9:13], 20, 22, 24, 25, 27, 31})
                    cc[5] = ~cc[5];
                if (b inside {4, [8:17], 26, 28, 30}) cc[6] = ~cc[6];
            end
        end
        return {cc, dd};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                chk("out_unexpected", {25'd0, out}, 64'hdead);
            else
                chk("out", {25'd0, out}, {25'd0, exp_q.pop_front()});
            exp_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && i_ovalid && i_oready) begin
            if (iexp_q.size() == 0)
                chk("inj_unexpected", {25'd0, i_out}, 64'hdead);
            else
                chk("inj_out", {25'd0, i_out}, {25'd0, iexp_q.pop_front()});
        end
    end

    task automatic send(input logic [31:0] dv, input logic [38:0] mv,
                        input logic [38:0] ev);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_valid = 1'b1;
        in_data  = dv;
        inj_mask = mv;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(ev);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic isend(input logic [31:0] dv, input logic [38:0] mv,
                         input logic [38:0] ev);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        i_valid = 1'b1;
        i_data  = dv;
        i_mask  = mv;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = i_ready;
            @(posedge clk);
            if (acc) iexp_q.push_back(ev);
            #1;
            n++;
        end
        i_valid = 1'b0;
        if (!acc) chk("isend_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input bit inj);
        int n;
        n = 0;
        while ((inj ? iexp_q.size() : exp_q.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(inj ? "inj_drain" : "drain",
            64'(inj ? iexp_q.size() : exp_q.size()), 64'd0);
    endtask

    // accept at edge E; valid must be absent after E, present after E+1
    task automatic lat_check(input logic [31:0] dv, input logic [38:0] ev);
        send(dv, 39'h0, ev);
        @(negedge clk);
        chk("lat_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] base;
        logic [31:0] w1, w2, w3, r;
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; inj_mask = 0; out_ready = 1;
        i_valid = 0; i_data = 0; i_mask = 0; i_oready = 1;
        #3;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out", {25'd0, out}, 64'd0);
        chk("rst_cnt", {48'd0, word_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_check(32'h0000_0001, 39'h07_0000_0001);
        chk("cnt_one", {48'd0, word_cnt}, 64'd1);

        send(32'hFFFF_FFFF, 39'h7F_FFFF_FFFF, 39'h24_FFFF_FFFF);
        send(32'h0000_0000, 39'h00_0000_0001, 39'h00_0000_0000);
        send(32'h8000_0000, 39'h55_1234_5678, 39'h34_8000_0000);
        send(32'h0000_0100, 39'h00_0000_0000, 39'h45_0000_0100);
        drain(1'b0);
        chk("cnt_five", {48'd0, word_cnt}, 64'd5);

        isend(32'h0000_0000, 39'h00_0000_0001, 39'h00_0000_0001);
        isend(32'h0000_0001, 39'h07_0000_0000, 39'h00_0000_0001);
        isend(32'hFFFF_FFFF, 39'h40_0000_0000, 39'h64_FFFF_FFFF);
        drain(1'b1);
        chk("inj_cnt", {48'd0, i_cnt}, 64'd3);

        // stall: two accepted, third blocked until drain
        w1 = 32'h1234_5678;
        w2 = 32'hCAFE_F00D;
        w3 = 32'h0BAD_BEEF;
        out_ready = 1'b0;
        send(w1, 39'h0, enc(w1));
        send(w2, 39'h0, enc(w2));
        @(negedge clk);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", {25'd0, out}, {25'd0, enc(w1)});
        end
        fork
            send(w3, 39'h0, enc(w3));
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(1'b0);
        chk("cnt_stall", {48'd0, word_cnt}, {48'd0, exp_cnt});

        base = exp_cnt;
        rnd = 1;
        fork
            while (rnd) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
            begin
                for (int k = 0; k < 100; k++) begin
                    r = $urandom;
                    send(r, {$urandom, $urandom}, enc(r));
                end
                rnd = 0;
            end
        join
        out_ready = 1'b1;
        drain(1'b0);
        chk("cnt_rand", {48'd0, word_cnt}, {48'd0, base + 16'd100});

        // reset with two words in flight
        out_ready = 1'b0;
        send(32'h1111_1111, 39'h0, enc(32'h1111_1111));
        send(32'h2222_2222, 39'h0, enc(32'h2222_2222));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_cnt", {48'd0, word_cnt}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_out", {25'd0, out}, 64'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        lat_check(32'h0000_0100, 39'h45_0000_0100);
        chk("post_rst_cnt", {48'd0, word_cnt}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
